// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a single-entry
// instruction register toward decode, and redirect handling that drains
// an in-flight request before refetching from the branch target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;         // address of the current/next request
    logic [31:0] pend, pend_n;     // redirect target held while draining
    logic [31:0] instr, instr_n;   // instruction register toward decode
    logic [31:0] ipc, ipc_n;       // PC of the held instruction
    logic [31:0] cnt, cnt_n;       // accepted-instruction counter
    logic [31:0] tgt;

    // Redirect targets are always word aligned before use.
    assign tgt = {i_redirect_pc[31:2], 2'b00};

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            pend  <= RESET_PC;
            instr <= NOP;
            ipc   <= RESET_PC;
            cnt   <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            pend  <= pend_n;
            instr <= instr_n;
            ipc   <= ipc_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and datapath update; redirect always takes priority over
    // capturing or handing off an instruction.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        instr_n = instr;
        ipc_n   = ipc;
        cnt_n   = cnt;
        unique case (state)
            S_FETCH: begin
                if (i_imem_ack && i_redirect) begin
                    // Returned word belongs to the wrong path: drop it.
                    pc_n = tgt;
                end else if (i_imem_ack) begin
                    instr_n = i_imem_rdata;
                    ipc_n   = pc;
                    state_n = S_VALID;
                end else if (i_redirect) begin
                    // Address must stay put until the memory answers.
                    pend_n  = tgt;
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_imem_ack) begin
                    // The freshest redirect wins, even in the ack cycle.
                    pc_n    = i_redirect ? tgt : pend;
                    state_n = S_FETCH;
                end else if (i_redirect) begin
                    pend_n = tgt;
                end
            end
            S_VALID: begin
                if (i_redirect) begin
                    pc_n    = tgt;
                    state_n = S_FETCH;
                end else if (i_ready) begin
                    pc_n    = pc + 32'd4;
                    cnt_n   = cnt + 32'd1;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // Request is suppressed while reset is held so nothing leaks out early.
    assign o_imem_req  = ~i_rst & (state != S_VALID);
    assign o_imem_addr = pc;
    assign o_valid     = (state == S_VALID);
    assign o_instr     = instr;
    assign o_pc        = ipc;
    assign o_pc_plus4  = ipc + 32'd4;
    assign o_fetch_cnt = cnt;

endmodule
